// File: rtl/uart_rx.sv
// Asynchronous serial receiver: synchronises the line, finds the start bit, samples each bit at
// mid-period, checks parity and stop bits, and presents each word with a one-cycle valid strobe.
module uart_rx #(
   parameter int DATA_BIT_COUNT   = 8,
   parameter int PARITY_BIT_COUNT = 0,
   parameter int PARITY_ODD       = 0,
   parameter int STOP_BIT_COUNT   = 1,
   parameter int CLK_PER_BIT      = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      serial,
   output logic [DATA_BIT_COUNT-1:0] data,
   output logic                      data_valid,
   output logic                      frame_error,
   output logic                      parity_error,
   output logic                      busy
);

   localparam int HALF = CLK_PER_BIT / 2;
   localparam int CW   = $clog2(CLK_PER_BIT) + 1;
   localparam int IW   = $clog2(DATA_BIT_COUNT);

   typedef enum logic [2:0] {
      SM_IDLE   = 3'd0,
      SM_START  = 3'd1,
      SM_DATA   = 3'd2,
      SM_PARITY = 3'd3,
      SM_STOP   = 3'd4,
      SM_BREAK  = 3'd5
   } state_t;

   state_t                    r_state;
   state_t                    w_next_state;
   logic                      r_sync0;
   logic                      r_sync1;
   logic [CW-1:0]             r_clock_count;
   logic [IW-1:0]             r_bit_idx;
   logic                      r_stop_idx;
   logic [DATA_BIT_COUNT-1:0] r_shift;
   logic                      r_ferr;
   logic                      r_par_err;

   logic w_rx_s;
   logic w_half_done;
   logic w_bit_done;
   logic w_last_data;
   logic w_last_stop;
   logic w_clr_cnt;
   logic w_shift_en;
   logic w_par_en;
   logic w_stop_en;
   logic w_done;

   assign w_rx_s      = r_sync1;
   assign w_half_done = (r_clock_count == CW'(HALF - 1));
   assign w_bit_done  = (r_clock_count == CW'(CLK_PER_BIT - 1));
   assign w_last_data = (r_bit_idx == IW'(DATA_BIT_COUNT - 1));
   assign w_last_stop = (r_stop_idx == 1'(STOP_BIT_COUNT - 1));
   assign busy        = (r_state != SM_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SM_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_clr_cnt    = 1'b0;
      w_shift_en   = 1'b0;
      w_par_en     = 1'b0;
      w_stop_en    = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         SM_IDLE: begin
            if (!w_rx_s) begin
               w_next_state = SM_START;
               w_clr_cnt    = 1'b1;
            end
         end
         SM_START: begin
            if (w_half_done) begin
               w_clr_cnt    = 1'b1;
               w_next_state = w_rx_s ? SM_IDLE : SM_DATA;
            end
         end
         SM_DATA: begin
            if (w_bit_done) begin
               w_clr_cnt  = 1'b1;
               w_shift_en = 1'b1;
               if (w_last_data) begin
                  w_next_state = (PARITY_BIT_COUNT > 0) ? SM_PARITY : SM_STOP;
               end
            end
         end
         SM_PARITY: begin
            if (w_bit_done) begin
               w_clr_cnt    = 1'b1;
               w_par_en     = 1'b1;
               w_next_state = SM_STOP;
            end
         end
         SM_STOP: begin
            if (w_bit_done) begin
               w_clr_cnt = 1'b1;
               w_stop_en = 1'b1;
               if (w_last_stop) begin
                  // Leaving mid-stop-bit gives the next start edge half a bit of slack.
                  w_done       = 1'b1;
                  w_next_state = (r_ferr || !w_rx_s) ? SM_BREAK : SM_IDLE;
               end
            end
         end
         SM_BREAK: begin
            if (w_rx_s) begin
               w_next_state = SM_IDLE;
            end
         end
         default: begin
            w_next_state = SM_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync0       <= 1'b1;
         r_sync1       <= 1'b1;
         r_clock_count <= '0;
         r_bit_idx     <= '0;
         r_stop_idx    <= 1'b0;
         r_shift       <= '0;
         r_ferr        <= 1'b0;
         r_par_err     <= 1'b0;
         data          <= '0;
         data_valid    <= 1'b0;
         frame_error   <= 1'b0;
         parity_error  <= 1'b0;
      end else begin
         r_sync0    <= serial;
         r_sync1    <= r_sync0;
         data_valid <= w_done;

         if (r_state == SM_IDLE || r_state == SM_BREAK || w_clr_cnt) begin
            r_clock_count <= '0;
         end else begin
            r_clock_count <= r_clock_count + 1'b1;
         end

         // Per-frame status is cleared while the start bit is being qualified.
         if (r_state == SM_START) begin
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_ferr     <= 1'b0;
            r_par_err  <= 1'b0;
         end

         if (w_shift_en) begin
            r_shift[r_bit_idx] <= w_rx_s;
            r_bit_idx          <= r_bit_idx + 1'b1;
         end

         if (w_par_en) begin
            r_par_err <= (^r_shift) ^ w_rx_s ^ 1'(PARITY_ODD);
         end

         if (w_stop_en) begin
            r_stop_idx <= r_stop_idx + 1'b1;
            if (!w_rx_s) begin
               r_ferr <= 1'b1;
            end
         end

         if (w_done) begin
            data         <= r_shift;
            frame_error  <= r_ferr | ~w_rx_s;
            parity_error <= r_par_err;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: an 8N1 instance and an 8E1 instance fed by behavioural transmitters.
module tb_uart_rx;

   localparam int CPB = 8;
   localparam int LAT = 79;

   logic       clk;
   logic       rst;
   logic       serial;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_error;
   logic       parity_error;
   logic       busy;
   logic       serial_p;
   logic [7:0] data_p;
   logic       data_valid_p;
   logic       frame_error_p;
   logic       parity_error_p;
   logic       busy_p;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic [7:0] d;
      logic       fe;
      logic       pe;
      bit         lat_chk;
      int         t0;
   } exp_t;

   exp_t q_main[$];
   exp_t q_par[$];
   exp_t e_main;
   exp_t e_par;

   uart_rx #(
      .DATA_BIT_COUNT(8), .PARITY_BIT_COUNT(0), .PARITY_ODD(0),
      .STOP_BIT_COUNT(1), .CLK_PER_BIT(CPB)
   ) dut (
      .clk(clk), .rst(rst), .serial(serial), .data(data), .data_valid(data_valid),
      .frame_error(frame_error), .parity_error(parity_error), .busy(busy)
   );

   uart_rx #(
      .DATA_BIT_COUNT(8), .PARITY_BIT_COUNT(1), .PARITY_ODD(0),
      .STOP_BIT_COUNT(1), .CLK_PER_BIT(CPB)
   ) dut_p (
      .clk(clk), .rst(rst), .serial(serial_p), .data(data_p), .data_valid(data_valid_p),
      .frame_error(frame_error_p), .parity_error(parity_error_p), .busy(busy_p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && data_valid) begin
         if (q_main.size() == 0) begin
            chk("spurious_strobe", 32'd1, 32'd0);
         end else begin
            e_main = q_main.pop_front();
            chk("data", 32'(data), 32'(e_main.d));
            chk("frame_error", 32'(frame_error), 32'(e_main.fe));
            chk("parity_error", 32'(parity_error), 32'(e_main.pe));
            if (e_main.lat_chk) chk("latency", 32'(cyc - e_main.t0), 32'(LAT));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && data_valid_p) begin
         if (q_par.size() == 0) begin
            chk("spurious_strobe_p", 32'd1, 32'd0);
         end else begin
            e_par = q_par.pop_front();
            chk("data_p", 32'(data_p), 32'(e_par.d));
            chk("frame_error_p", 32'(frame_error_p), 32'(e_par.fe));
            chk("parity_error_p", 32'(parity_error_p), 32'(e_par.pe));
         end
      end
   end

   // Called just after a falling clock edge; holds the level for one bit period.
   task automatic drive_bit(input logic v);
      serial = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic drive_bit_p(input logic v);
      serial_p = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_v, input bit lat_chk);
      exp_t e;
      e.d = b; e.fe = ~stop_v; e.pe = 1'b0; e.lat_chk = lat_chk; e.t0 = cyc;
      q_main.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_v);
   endtask

   task automatic send_byte_p(input logic [7:0] b, input logic par_v);
      exp_t e;
      e.d = b; e.fe = 1'b0; e.pe = par_v ^ (^b); e.lat_chk = 1'b0; e.t0 = cyc;
      q_par.push_back(e);
      drive_bit_p(1'b0);
      for (int i = 0; i < 8; i++) drive_bit_p(b[i]);
      drive_bit_p(par_v);
      drive_bit_p(1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_data"}, 32'(data), 32'd0);
      chk({tag, "_valid"}, 32'(data_valid), 32'd0);
      chk({tag, "_ferr"}, 32'(frame_error), 32'd0);
      chk({tag, "_perr"}, 32'(parity_error), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   logic [7:0] abort_byte;

   initial begin
      rst = 1'b1;
      serial = 1'b1;
      serial_p = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      chk("reset_p_data", 32'(data_p), 32'd0);
      chk("reset_p_busy", 32'(busy_p), 32'd0);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_valid", 32'(data_valid), 32'd0);

      send_byte(8'hA5, 1'b1, 1'b1);
      send_byte(8'h00, 1'b1, 1'b0);
      send_byte(8'hFF, 1'b1, 1'b0);
      send_byte(8'h3C, 1'b1, 1'b0);
      repeat (20) @(negedge clk);

      serial = 1'b0;
      repeat (2) @(negedge clk);
      serial = 1'b1;
      repeat (3) @(negedge clk);
      chk("glitch_busy_start", 32'(busy), 32'd1);
      repeat (20) @(negedge clk);
      chk("glitch_back_idle", 32'(busy), 32'd0);

      send_byte(8'h55, 1'b0, 1'b0);
      repeat (30) @(negedge clk);
      chk("break_busy", 32'(busy), 32'd1);
      serial = 1'b1;
      repeat (20) @(negedge clk);
      chk("break_released", 32'(busy), 32'd0);
      send_byte(8'h12, 1'b1, 1'b0);
      repeat (20) @(negedge clk);

      abort_byte = 8'hF0;
      serial = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) drive_bit(abort_byte[i]);
      serial = abort_byte[4];
      repeat (CPB / 2) @(negedge clk);
      chk("midframe_busy", 32'(busy), 32'd1);
      chk("midframe_held_data", 32'(data), 32'h12);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("midframe_rst");
      serial = 1'b1;
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("post_rst_idle", 32'(busy), 32'd0);
      send_byte(8'hC3, 1'b1, 1'b0);
      repeat (20) @(negedge clk);

      send_byte_p(8'h07, 1'b1);
      send_byte_p(8'h07, 1'b0);
      repeat (20) @(negedge clk);

      chk("main_queue_drained", 32'(q_main.size()), 32'd0);
      chk("par_queue_drained", 32'(q_par.size()), 32'd0);
      chk("final_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
